mem_handshake_ram: RTL and testbench
====================================

Name: mem_handshake_ram

Overview:
- Byte-addressable data/instruction RAM that sits directly downstream of the multicycle control unit.
- Consumes the MAR address, MDR write data and the memEnable/RW/byte/unSign strobes. Returns read data to the MDR/IR path and signals completion on MOC.
- Models a fixed, parameterised access latency so the control FSM's MOC wait states are exercised realistically.
- Big-endian, 32-bit words.

Parameters:
- DEPTH, 512, memory size in bytes; power of two, at least 4.
- LATENCY, 2, cycles from request acceptance to MOC assertion; at least 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- memEnable  in  1  request strobe; held high by the requester until MOC is seen.
- RW  in  1  0 = read, 1 = write.
- byte  in  1  1 = byte access, 0 = word access.
- unSign  in  1  byte reads only: 1 = zero-extend, 0 = sign-extend.
- address  in  32  byte address (MAR).
- dataIn  in  32  write data (MDR); byte writes use dataIn[7:0].
- dataOut  out  32  read data; holds its value until the next read completes.
- MOC  out  1  memory operation complete.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, MOC=0, dataOut=0, latency counter=0, latched request registers=0. Memory array contents are not cleared by reset.
- Address mapping: effective byte address = address mod DEPTH, so high bits are ignored and accesses wrap.
- Word accesses ignore address[1:0] and use base = effective address with bits [1:0] cleared.
- Word layout: mem[base] = bits[31:24] … mem[base+3] = bits[7:0].
- Byte access uses the full effective address.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - MOC=0.
  - If memEnable=1 at a rising edge: latch address, dataIn, RW, byte, unSign; load counter=LATENCY-1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Inputs are ignored; only the latched copies are used.
  - If counter≠0: decrement and stay.
  - If counter=0: perform the access on this edge, set MOC=1, go to DONE.
  - Net timing: a request sampled at edge N completes (MOC rises, write committed, dataOut valid) at edge N+LATENCY.
- Read, word: dataOut = {mem[base], mem[base+1], mem[base+2], mem[base+3]}.
- Read, byte: dataOut = the byte, zero-extended if unSign=1, otherwise sign-extended from bit 7.
- Write, word: all four bytes written. Write, byte: only mem[addr] written.
- dataOut is unchanged on writes.
- DONE:
  - MOC stays 1 while memEnable=1.
  - When memEnable=0 is sampled: MOC←0 and go to IDLE on that same edge.
  - A new request is accepted no earlier than the edge after the return to IDLE, so every transaction gets exactly one MOC pulse.
- memEnable dropping during BUSY:
  - The access still completes at N+LATENCY.
  - The FSM enters DONE, then sees memEnable=0 and returns to IDLE the following edge, so MOC is high for exactly one cycle.
- Reset asserted mid-transaction:
  - In BUSY: the pending write is not committed and no MOC is issued.
  - In DONE: the memory content already written remains.
- Simultaneous read and write: not possible, since RW selects exactly one.
- Back-to-back requests to the same location: read-after-write returns the newly written data.

Test Plan:
- Word write, then word read: write address=0x10, dataIn=0xDEADBEEF, RW=1, byte=0 → MOC rises exactly 2 edges after acceptance. Then read 0x10 → dataOut=0xDEADBEEF; mem[0x10]=0xDE, mem[0x13]=0xEF.
- Byte extension: after the write above, byte read at 0x11 with unSign=0 → 0xFFFFFFAD; with unSign=1 → 0x000000AD. Byte write 0x5A to 0x12, then word read 0x10 → 0xDEAD5ABE? No: 0xDEAD5AEF.
- Alignment and wrap: word read at address 0x13 returns the same word as 0x10. Word write 0x11223344 to address 0x210 (DEPTH=512) → a word read at 0x010 returns 0x11223344.
- Handshake: hold memEnable high 3 cycles after MOC → MOC stays high throughout, then falls the edge after memEnable=0. Pulse memEnable for 1 cycle only → exactly one 1-cycle MOC pulse at N+2.
- Mid-operation reset: word write of 0xCAFEF00D to 0x20, with reset=0 asserted one cycle after acceptance → MOC never rises, dataOut=0, and a later read of 0x20 returns the prior contents.
- LATENCY=1 build: request sampled at edge N → MOC=1 at edge N+1; a read following a write returns the written data.

Source files
------------

// File: rtl/mem_handshake_ram_if.sv
// Request/response bundle between the multicycle control unit and the RAM.
// The byte-access strobe is named byteMode because "byte" is a reserved word.
interface mem_handshake_ram_if;
    logic        memEnable;
    logic        RW;
    logic        byteMode;
    logic        unSign;
    logic [31:0] address;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        MOC;

    modport master (
        output memEnable, RW, byteMode, unSign, address, dataIn,
        input  dataOut, MOC
    );

    modport slave (
        input  memEnable, RW, byteMode, unSign, address, dataIn,
        output dataOut, MOC
    );
endinterface

// File: rtl/mem_handshake_ram.sv
// Big-endian byte-addressable RAM with a fixed access latency and a MOC handshake.
// Storage is four byte lanes, where lane k holds byte k (MSB first) of each word.
module mem_handshake_ram #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_handshake_ram_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = (AW > 2) ? AW - 2 : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [AW-1:0] addr_reg;
    logic [31:0]   data_reg;
    logic          rw_reg;
    logic          byte_reg;
    logic          unsign_reg;
    logic [31:0]   dout_reg;

    logic          accept;
    logic          access;
    logic [IW-1:0] idx;
    logic [1:0]    lane;
    logic [7:0]    rd_lane [4];
    logic [7:0]    rd_byte;
    logic [31:0]   rd_value;

    assign accept = (state_reg == IDLE) && bus.memEnable;
    assign access = (state_reg == BUSY) && (cnt_reg == '0);
    assign lane   = addr_reg[1:0];

    generate
        if (AW > 2) begin : g_idx
            assign idx = addr_reg[AW-1:2];
        end else begin : g_idx_single
            assign idx = '0;
        end
    endgenerate

    // One byte-wide array per lane; writes happen only on the completing edge.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] bank [DEPTH/4];
            logic       we;
            logic [7:0] wdata;

            assign we    = access && rw_reg && (!byte_reg || (lane == 2'(gi)));
            assign wdata = byte_reg ? data_reg[7:0] : data_reg[31-8*gi -: 8];

            always_ff @(posedge clk) begin
                if (we) begin
                    bank[idx] <= wdata;
                end
            end

            assign rd_lane[gi] = bank[idx];
        end
    endgenerate

    always_comb begin
        rd_byte = rd_lane[lane];
        if (!byte_reg) begin
            rd_value = {rd_lane[0], rd_lane[1], rd_lane[2], rd_lane[3]};
        end else if (unsign_reg) begin
            rd_value = {24'h0, rd_byte};
        end else begin
            rd_value = {{24{rd_byte[7]}}, rd_byte};
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.memEnable) state_next = BUSY;
            BUSY:    if (cnt_reg == '0) state_next = DONE;
            DONE:    if (!bus.memEnable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: MOC is a decode of the registered state, so it is glitch-free
    always_comb begin
        bus.MOC     = (state_reg == DONE);
        bus.dataOut = dout_reg;
    end

    // Request latch, latency counter and read-data register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg    <= '0;
            addr_reg   <= '0;
            data_reg   <= '0;
            rw_reg     <= 1'b0;
            byte_reg   <= 1'b0;
            unsign_reg <= 1'b0;
            dout_reg   <= '0;
        end else begin
            if (accept) begin
                addr_reg   <= bus.address[AW-1:0];
                data_reg   <= bus.dataIn;
                rw_reg     <= bus.RW;
                byte_reg   <= bus.byteMode;
                unsign_reg <= bus.unSign;
                cnt_reg    <= CNT_LOAD;
            end else if ((state_reg == BUSY) && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
            if (access && !rw_reg) begin
                dout_reg <= rd_value;
            end
        end
    end
endmodule

// File: tb/tb_mem_handshake_ram.sv
// Directed bench: a vector table of transactions on a LATENCY=2 instance plus
// hand sequences for handshake timing, mid-transaction reset and a LATENCY=1 build.
module tb_mem_handshake_ram;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    mem_handshake_ram_if bus0();
    mem_handshake_ram_if bus1();

    mem_handshake_ram #(.DEPTH(512), .LATENCY(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    mem_handshake_ram #(.DEPTH(512), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        bm;
        logic        us;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive0(input logic en, input logic rw, input logic bm, input logic us,
                          input logic [31:0] addr, input logic [31:0] din);
        bus0.memEnable = en;
        bus0.RW        = rw;
        bus0.byteMode  = bm;
        bus0.unSign    = us;
        bus0.address   = addr;
        bus0.dataIn    = din;
    endtask

    task automatic drive1(input logic en, input logic rw, input logic bm, input logic us,
                          input logic [31:0] addr, input logic [31:0] din);
        bus1.memEnable = en;
        bus1.RW        = rw;
        bus1.byteMode  = bm;
        bus1.unSign    = us;
        bus1.address   = addr;
        bus1.dataIn    = din;
    endtask

    // Full transaction on dut0: expects MOC exactly 2 edges after acceptance
    task automatic txn0(input string tag, input vec_t v);
        int cyc;
        bit got;
        @(negedge clk);
        drive0(1'b1, v.rw, v.bm, v.us, v.addr, v.din);
        @(posedge clk);
        cyc = 0;
        got = 0;
        while (cyc < 20 && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus0.MOC) got = 1;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd2);
        check({tag, "_dataOut"}, bus0.dataOut, v.exp);
        $display("txn %s rw=%0b byte=%0b uns=%0b addr=%h din=%h -> dataOut=%h after %0d edges",
                 tag, v.rw, v.bm, v.us, v.addr, v.din, bus0.dataOut, cyc);
        @(negedge clk);
        bus0.memEnable = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_moc_drop"}, 32'(bus0.MOC), 32'd0);
    endtask

    // Full transaction on dut1: expects MOC exactly 1 edge after acceptance
    task automatic txn1(input string tag, input vec_t v);
        @(negedge clk);
        drive1(1'b1, v.rw, v.bm, v.us, v.addr, v.din);
        @(posedge clk);
        #1;
        check({tag, "_moc_n0"}, 32'(bus1.MOC), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_moc_n1"}, 32'(bus1.MOC), 32'd1);
        check({tag, "_dataOut"}, bus1.dataOut, v.exp);
        $display("txn %s rw=%0b byte=%0b addr=%h din=%h -> dataOut=%h", tag, v.rw, v.bm,
                 v.addr, v.din, bus1.dataOut);
        @(negedge clk);
        bus1.memEnable = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_moc_drop"}, 32'(bus1.MOC), 32'd0);
    endtask

    initial begin
        vec_t v;
        n_cmp = 0;
        n_bad = 0;

        //            rw    bm    us    addr          din           expected dataOut
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0011, 32'h0,         32'hFFFF_FFAD};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0011, 32'h0,         32'h0000_00AD};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0012, 32'hFFFF_FF5A, 32'h0000_00AD};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_5AEF};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_5AEF};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0,         32'h0000_00DE};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'hFFFF_FFEF};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0210, 32'h1122_3344, 32'hFFFF_FFEF};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h1122_3344};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0000_01FC, 32'h0102_0380, 32'h1122_3344};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0000_01FF, 32'h0,         32'hFFFF_FF80};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h8000_03FD, 32'h0,         32'h0000_0002};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h1357_9BDF, 32'h0000_0002};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0000_0021, 32'h0,         32'h0000_0057};

        reset = 1'b0;
        drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_moc", 32'(bus0.MOC), 32'd0);
        check("reset_dataOut", bus0.dataOut, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            txn0($sformatf("vec%0d", i), vecs[i]);
        end

        // Hold memEnable 3 cycles past MOC: MOC must stay high, then fall one edge after release
        begin
            int cyc;
            bit got;
            @(negedge clk);
            drive0(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0);
            @(posedge clk);
            cyc = 0;
            got = 0;
            while (cyc < 20 && !got) begin
                @(posedge clk);
                #1;
                cyc++;
                if (bus0.MOC) got = 1;
            end
            check("hold_latency", 32'(cyc), 32'd2);
            check("hold_dataOut", bus0.dataOut, 32'h1357_9BDF);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk);
                #1;
                check($sformatf("hold_moc_high%0d", k), 32'(bus0.MOC), 32'd1);
            end
            @(negedge clk);
            bus0.memEnable = 1'b0;
            @(posedge clk);
            #1;
            check("hold_moc_drop", 32'(bus0.MOC), 32'd0);
            $display("txn hold read addr=00000020 -> dataOut=%h, MOC held 3 extra cycles",
                     bus0.dataOut);
        end

        // Single-cycle memEnable pulse: exactly one MOC pulse at N+2
        @(negedge clk);
        drive0(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0);
        @(posedge clk);
        #1;
        check("pulse_moc_n0", 32'(bus0.MOC), 32'd0);
        @(negedge clk);
        bus0.memEnable = 1'b0;
        @(posedge clk);
        #1;
        check("pulse_moc_n1", 32'(bus0.MOC), 32'd0);
        @(posedge clk);
        #1;
        check("pulse_moc_n2", 32'(bus0.MOC), 32'd1);
        check("pulse_dataOut", bus0.dataOut, 32'h0000_0011);
        @(posedge clk);
        #1;
        check("pulse_moc_n3", 32'(bus0.MOC), 32'd0);
        @(posedge clk);
        #1;
        check("pulse_moc_n4", 32'(bus0.MOC), 32'd0);
        $display("txn pulse byte read addr=00000010 -> dataOut=%h", bus0.dataOut);

        // Reset one cycle after accepting a write: nothing commits, no MOC
        @(negedge clk);
        drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'hCAFE_F00D);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_moc", 32'(bus0.MOC), 32'd0);
        check("midrst_dataOut", bus0.dataOut, 32'h0);
        @(negedge clk);
        bus0.memEnable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("midrst_moc_hold%0d", k), 32'(bus0.MOC), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        $display("txn aborted write addr=00000020 din=cafef00d by reset");
        v = '{1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h1357_9BDF};
        txn0("midrst_readback", v);

        // LATENCY=1 instance
        v = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'hA5A5_0F0F, 32'h0000_0000};
        txn1("lat1_write", v);
        v = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'hA5A5_0F0F};
        txn1("lat1_read", v);
        v = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hFFFF_FFA5};
        txn1("lat1_byte", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end
endmodule
